fc2_bias_adder: RTL and testbench

Reader and consumer for the FC2 bias ROM. For each FC2 output batch it fetches the bias word from the ROM and adds it lane-wise to the accumulator vector from the FC2 MAC array. It saturates each sum to the output width and presents the result downstream with a valid/ready handshake. It sits between the FC2 MAC array and the FC2 output buffer, and is the only master of the bias ROM's read port.

---
 rtl/fc2_bias_adder_pkg.sv | 23 ++
 rtl/fc2_bias_sat_add.sv | 41 ++++
 rtl/fc2_bias_adder.sv | 105 ++++++++++
 tb/tb_fc2_bias_adder.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc2_bias_adder_pkg.sv
// Shared constants and FSM encoding for the FC2 bias adder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fc2_bias_adder_pkg;

    // Geometry of the FC2 output stage (outputs per batch, batches per inference).
    localparam int FC2_N_LANE  = 16;
    localparam int FC2_N_BATCH = 2;
    // Lane widths: signed bias, signed accumulator, signed saturated output.
    localparam int FC2_W_BIAS  = 34;
    localparam int FC2_W_ACC   = 34;
    localparam int FC2_W_OUT   = 32;
    // Bias ROM address width (one word per batch).
    localparam int FC2_W_ADDR  = 1;

    // FSM encoding, kept as plain constants for compatibility with older tools.
    typedef logic [1:0] state_t;
    localparam state_t S_FETCH = 2'd0;
    localparam state_t S_LATCH = 2'd1;
    localparam state_t S_WAIT  = 2'd2;
    localparam state_t S_OUT   = 2'd3;

endpackage

// File: rtl/fc2_bias_sat_add.sv
// One lane: signed accumulator + signed bias, saturated to the output width.
// Latency: purely combinational.
// Backpressure: none (no state).
module fc2_bias_sat_add
    import fc2_bias_adder_pkg::*;
#(
    parameter int W_A = FC2_W_ACC,
    parameter int W_B = FC2_W_BIAS,
    parameter int W_O = FC2_W_OUT
) (
    input  logic [W_A-1:0] acc,
    input  logic [W_B-1:0] bias,
    output logic [W_O-1:0] sum_sat
);

    // One guard bit above the wider operand so the raw sum can never wrap.
    localparam int W_S = ((W_A > W_B) ? W_A : W_B) + 1;

    logic signed [W_S-1:0] acc_x;
    logic signed [W_S-1:0] bias_x;
    logic signed [W_S-1:0] sum;
    logic signed [W_S-1:0] max_v;
    logic signed [W_S-1:0] min_v;

    assign acc_x  = W_S'($signed(acc));
    assign bias_x = W_S'($signed(bias));
    assign sum    = acc_x + bias_x;
    assign max_v  = W_S'({1'b0, {(W_O-1){1'b1}}});
    assign min_v  = ~max_v;

    // Clamp the full-precision sum into the signed output range.
    always_comb begin
        sum_sat = sum[W_O-1:0];
        if (sum > max_v) begin
            sum_sat = max_v[W_O-1:0];
        end else if (sum < min_v) begin
            sum_sat = min_v[W_O-1:0];
        end
    end

endmodule

// File: rtl/fc2_bias_adder.sv
// Fetches the per-batch bias word from the FC2 bias ROM and adds it lane-wise, saturated, to the MAC accumulators.
// Latency: ROM read, latch, then result registered one cycle after the acc handshake (min 4 cycles per batch).
// Backpressure: result held stable until out_ready; acc_ready only in S_WAIT, so upstream stalls while a result is pending.
module fc2_bias_adder
    import fc2_bias_adder_pkg::*;
#(
    parameter int N_LANE  = FC2_N_LANE,
    parameter int N_BATCH = FC2_N_BATCH,
    parameter int W_BIAS  = FC2_W_BIAS,
    parameter int W_ACC   = FC2_W_ACC,
    parameter int W_OUT   = FC2_W_OUT,
    parameter int W_ADDR  = FC2_W_ADDR
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      flush,
    output logic [W_ADDR-1:0]         rom_aa,
    output logic                      rom_cena,
    input  logic [N_LANE*W_BIAS-1:0]  rom_qa,
    input  logic                      acc_valid,
    output logic                      acc_ready,
    input  logic [N_LANE*W_ACC-1:0]   acc_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [N_LANE*W_OUT-1:0]   out_data,
    output logic                      out_last
);

    state_t                     state;
    logic [W_ADDR-1:0]          batch_cnt;
    logic [N_LANE*W_BIAS-1:0]   bias_reg;
    logic [N_LANE*W_OUT-1:0]    sat_sum;
    logic                       is_last;

    assign is_last   = (batch_cnt == W_ADDR'(N_BATCH - 1));
    // Outputs decode from state only, so no input reaches an output combinationally.
    assign rom_aa    = batch_cnt;
    assign rom_cena  = (state != S_FETCH);
    assign acc_ready = (state == S_WAIT);

    // Lane 0 sits in the MSBs of every packed vector.
    for (genvar i = 0; i < N_LANE; i++) begin : g_lane
        fc2_bias_sat_add #(
            .W_A (W_ACC),
            .W_B (W_BIAS),
            .W_O (W_OUT)
        ) u_sat_add (
            .acc     (acc_data[(N_LANE-1-i)*W_ACC +: W_ACC]),
            .bias    (bias_reg[(N_LANE-1-i)*W_BIAS +: W_BIAS]),
            .sum_sat (sat_sum[(N_LANE-1-i)*W_OUT +: W_OUT])
        );
    end

    // Batch sequencing: fetch, latch bias, wait for accumulators, drain result.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_FETCH;
            batch_cnt <= '0;
        end else if (flush) begin
            state     <= S_FETCH;
            batch_cnt <= '0;
        end else begin
            case (state)
                S_FETCH: state <= S_LATCH;
                S_LATCH: state <= S_WAIT;
                S_WAIT:  if (acc_valid) state <= S_OUT;
                S_OUT: begin
                    if (out_ready) begin
                        state     <= S_FETCH;
                        batch_cnt <= is_last ? '0 : batch_cnt + 1'b1;
                    end
                end
                default: state <= S_FETCH;
            endcase
        end
    end

    // Capture the ROM word the cycle after the read was issued.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bias_reg <= '0;
        end else if (state == S_LATCH) begin
            bias_reg <= rom_qa;
        end
    end

    // Result register: loads on the acc handshake, clears valid on drain or flush.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if ((state == S_WAIT) && acc_valid) begin
            out_valid <= 1'b1;
            out_data  <= sat_sum;
            out_last  <= is_last;
        end else if ((state == S_OUT) && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fc2_bias_adder.sv
// Self-checking bench for fc2_bias_adder: directed test-plan cases plus randomized batches.
// Latency: n/a.
// Backpressure: random out_ready stalls exercised.
module tb_fc2_bias_adder;
    import fc2_bias_adder_pkg::*;

    localparam int NL  = FC2_N_LANE;
    localparam int NB  = FC2_N_BATCH;
    localparam int WB  = FC2_W_BIAS;
    localparam int WA  = FC2_W_ACC;
    localparam int WO  = FC2_W_OUT;
    localparam int WAD = FC2_W_ADDR;
    localparam int DW  = NL * WO;
    localparam longint OMAX = (longint'(1) <<< (WO - 1)) - 1;
    localparam longint OMIN = -OMAX - 1;

    logic               clk;
    logic               rstn;
    logic               flush;
    logic [WAD-1:0]     rom_aa;
    logic               rom_cena;
    logic [NL*WB-1:0]   rom_qa;
    logic               acc_valid;
    logic               acc_ready;
    logic [NL*WA-1:0]   acc_data;
    logic               out_valid;
    logic               out_ready;
    logic [DW-1:0]      out_data;
    logic               out_last;

    fc2_bias_adder dut (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (flush),
        .rom_aa    (rom_aa),
        .rom_cena  (rom_cena),
        .rom_qa    (rom_qa),
        .acc_valid (acc_valid),
        .acc_ready (acc_ready),
        .acc_data  (acc_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] dat;
        logic          last;
    } exp_t;

    logic [WB-1:0] rom [NB][NL];
    exp_t          expq[$];
    int            total = 0;
    int            bad = 0;
    int            mbatch = 0;
    int            cena_cnt = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout want event", name);
    endtask

    function automatic logic [WB-1:0] rand34();
        logic [63:0] r;
        int          m;
        r = {$urandom(), $urandom()};
        m = $urandom_range(0, 2);
        case (m)
            0:       return WB'(r);
            1:       return WB'($signed(r[31:0]));
            default: return WB'($signed(r[15:0]));
        endcase
    endfunction

    function automatic logic [NL*WA-1:0] rand_acc();
        logic [NL*WA-1:0] d;
        for (int i = 0; i < NL; i++) d[(NL-1-i)*WA +: WA] = WA'(rand34());
        return d;
    endfunction

    // Reference: plain integer add of acc and the ROM bias of batch b, clamped.
    function automatic logic [DW-1:0] model(input logic [NL*WA-1:0] acc, input int b);
        logic [DW-1:0] r;
        longint        a;
        longint        bi;
        longint        s;
        r = '0;
        for (int i = 0; i < NL; i++) begin
            a  = longint'($signed(acc[(NL-1-i)*WA +: WA]));
            bi = longint'($signed(rom[b][i]));
            s  = a + bi;
            if (s > OMAX) s = OMAX;
            else if (s < OMIN) s = OMIN;
            r[(NL-1-i)*WO +: WO] = WO'(s);
        end
        return r;
    endfunction

    function automatic logic [WO-1:0] lane_of(input logic [DW-1:0] d, input int i);
        return d[(NL-1-i)*WO +: WO];
    endfunction

    // Synchronous ROM: data appears the cycle after an active-low read.
    always @(posedge clk) begin
        if (!rom_cena) begin
            for (int i = 0; i < NL; i++) rom_qa[(NL-1-i)*WB +: WB] <= rom[rom_aa][i];
        end
    end

    // Compare process: checks outputs every cycle, then advances the model for the coming edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rstn) begin
            expq.delete();
            mbatch = 0;
        end else begin
            if (!rom_cena) begin
                cena_cnt++;
                check("rom_aa", DW'(rom_aa), DW'(mbatch));
            end
            check("out_valid", DW'(out_valid), DW'(expq.size() != 0));
            if (out_valid && expq.size() != 0) begin
                check("out_data", out_data, expq[0].dat);
                check("out_last", DW'(out_last), DW'(expq[0].last));
            end
            if (flush) begin
                expq.delete();
                mbatch = 0;
            end else begin
                if (out_valid && out_ready && expq.size() != 0) begin
                    void'(expq.pop_front());
                    mbatch = (mbatch + 1) % NB;
                end
                if (acc_valid && acc_ready) begin
                    e.dat  = model(acc_data, mbatch);
                    e.last = (mbatch == NB - 1);
                    expq.push_back(e);
                end
            end
        end
    end

    task automatic send_acc(input logic [NL*WA-1:0] d);
        bit ok;
        ok = 0;
        acc_data  = d;
        acc_valid = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (acc_ready) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        acc_valid = 1'b0;
        if (!ok) fail("acc_handshake");
    endtask

    task automatic recv(input int stall);
        bit ok;
        ok = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            fail("out_wait");
        end else begin
            repeat (stall) @(posedge clk);
            @(posedge clk);
            #1;
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic wait_cena(input string name, input int exp_aa);
        bit ok;
        ok = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rstn && !rom_cena) begin
                ok = 1;
                break;
            end
        end
        if (ok) check(name, DW'(rom_aa), DW'(exp_aa));
        else    fail(name);
    endtask

    initial begin
        logic [NL*WA-1:0] d;
        bit               ok;

        rstn      = 1'b0;
        flush     = 1'b0;
        acc_valid = 1'b0;
        acc_data  = '0;
        out_ready = 1'b0;
        for (int b = 0; b < NB; b++)
            for (int i = 0; i < NL; i++) rom[b][i] = rand34();
        rom[0][0]  = WB'(176565280);
        rom[0][3]  = WB'(750612416);
        rom[1][11] = WB'(-672013056);

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", DW'(out_valid), 0);
        check("rst_out_data",  out_data, 0);
        check("rst_out_last",  DW'(out_last), 0);
        check("rst_rom_cena",  DW'(rom_cena), 0);
        check("rst_acc_ready", DW'(acc_ready), 0);
        rstn = 1'b1;

        // Batch 0: nominal add and positive saturation.
        d = rand_acc();
        d[(NL-1-0)*WA +: WA] = WA'(100);
        d[(NL-1-3)*WA +: WA] = WA'(2000000000);
        send_acc(d);
        @(negedge clk);
        check("nom_lane0",  DW'(lane_of(out_data, 0)), 176565380);
        check("pos_sat",    DW'(lane_of(out_data, 3)), 32'h7fffffff);
        check("nom_last",   DW'(out_last), 0);
        check("nom_cena1",  DW'(cena_cnt), 1);
        recv(0);

        // Batch 1: negative saturation, last flag, wrap of the ROM address.
        d = rand_acc();
        d[(NL-1-11)*WA +: WA] = WA'(-1600000000);
        send_acc(d);
        @(negedge clk);
        check("neg_sat",  DW'(lane_of(out_data, 11)), 32'h80000000);
        check("neg_last", DW'(out_last), 1);
        recv(2);
        wait_cena("wrap_aa", 0);

        // Batch 0 again: 10 cycles of backpressure.
        send_acc(rand_acc());
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("bp_acc_ready", DW'(acc_ready), 0);
            check("bp_rom_cena",  DW'(rom_cena), 1);
            check("bp_valid",     DW'(out_valid), 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        wait_cena("bp_next_aa", 1);
        check("bp_drained", DW'(out_valid), 0);

        // Batch 1: flush while the result is pending.
        send_acc(rand_acc());
        @(negedge clk);
        check("flush_pre_valid", DW'(out_valid), 1);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        wait_cena("flush_aa", 0);
        check("flush_valid", DW'(out_valid), 0);
        check("flush_last",  DW'(out_last), 0);

        // Asynchronous reset while waiting for accumulators.
        ok = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (acc_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) fail("wait_state");
        #3;
        rstn = 1'b0;
        #1;
        check("arst_out_valid", DW'(out_valid), 0);
        check("arst_out_data",  out_data, 0);
        check("arst_out_last",  DW'(out_last), 0);
        check("arst_rom_cena",  DW'(rom_cena), 0);
        check("arst_acc_ready", DW'(acc_ready), 0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        wait_cena("arst_aa", 0);

        // Randomized batches with random gaps and output stalls.
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    send_acc(rand_acc());
                end
            end
            begin
                for (int k = 0; k < 40; k++) recv($urandom_range(0, 3));
            end
        join

        repeat (3) @(posedge clk);
        #1;
        check("drain_empty", DW'(expq.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
